// File: rtl/bus_pkg.sv
// Shared bus-source definitions: arbitration mode codes, default source count,
// and the multi-request detect used by the grant encoder.
package bus_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int BUS_SRC_N  = 24;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // True when more than one bit of v is set (clearing the lowest set bit leaves something).
    function automatic logic multi_hot(input logic [63:0] v);
        return (v & (v - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/bus_grant_encoder_prio_pick.sv
// Combinational wrap-around priority picker: returns the first set request bit
// found scanning upward from a start index, wrapping N-1 -> 0.
module prio_pick #(
    parameter int N = 24,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;

    // Rotate the request vector so the start index lands at bit 0.
    always_comb begin
        dbl_s = {req, req} >> start;
        rot_s = dbl_s[N-1:0];
    end

    // Lowest set bit of the rotated vector, then map the offset back to a real index.
    always_comb begin
        int off;
        int sum;
        off   = 0;
        sum   = 0;
        found = 1'b0;
        idx   = {W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off   = k;
                found = 1'b1;
            end else begin
                off   = off;
                found = found;
            end
        end
        sum = int'(start) + off;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        idx = W'(sum);
    end

endmodule

// File: rtl/bus_grant_encoder.sv
// Registered bus grant encoder: turns bus-drive requests into a binary source
// select with valid flag, grant hold, sticky collision flag, and either
// fixed (highest index wins) or round-robin arbitration.
module bus_grant_encoder import bus_pkg::*; #(
    parameter int N    = BUS_SRC_N,
    parameter int W    = $clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         hold,
    input  logic         err_clear,
    output logic [W-1:0] sel_out,
    output logic         sel_valid,
    output logic         collision
);

    logic [W-1:0] sel_out_r;
    logic         sel_valid_r;
    logic         collision_r;
    logic [W-1:0] last_r;

    logic [N-1:0] req_rev_s;
    logic [N-1:0] pick_req_s;
    logic [W-1:0] rr_start_s;
    logic [W-1:0] pick_start_s;
    logic         pick_found_s;
    logic [W-1:0] pick_idx_s;
    logic [W-1:0] grant_idx_s;
    logic         multi_s;

    // Bit-reverse the requests so a lowest-first pick yields the highest index.
    always_comb begin
        req_rev_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            req_rev_s[i] = req[N-1-i];
        end
    end

    // Round-robin search starts just past the last grant, wrapping at N-1 rather than 2^W-1.
    always_comb begin
        if (last_r == W'(N - 1)) begin
            rr_start_s = {W{1'b0}};
        end else begin
            rr_start_s = last_r + W'(1'b1);
        end
    end

    // Steer the single picker for the configured mode and map its result back.
    always_comb begin
        if (MODE == MODE_RR) begin
            pick_req_s   = req;
            pick_start_s = rr_start_s;
            grant_idx_s  = pick_idx_s;
        end else begin
            pick_req_s   = req_rev_s;
            pick_start_s = {W{1'b0}};
            grant_idx_s  = W'(N - 1) - pick_idx_s;
        end
    end

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (pick_req_s),
        .start (pick_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // More than one source asking for the bus in the same cycle.
    always_comb begin
        multi_s = multi_hot(64'(req));
    end

    // Grant, valid, round-robin pointer and sticky collision state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_out_r   <= {W{1'b0}};
            sel_valid_r <= 1'b0;
            collision_r <= 1'b0;
            last_r      <= W'(N - 1);
        end else begin
            collision_r <= (collision_r & ~err_clear) | multi_s;
            if (hold && sel_valid_r) begin
                sel_out_r   <= sel_out_r;
                sel_valid_r <= sel_valid_r;
                last_r      <= last_r;
            end else if (!pick_found_s) begin
                sel_out_r   <= sel_out_r;
                sel_valid_r <= 1'b0;
                last_r      <= last_r;
            end else begin
                sel_out_r   <= grant_idx_s;
                sel_valid_r <= 1'b1;
                if (MODE == MODE_RR) begin
                    last_r <= grant_idx_s;
                end else begin
                    last_r <= last_r;
                end
            end
        end
    end

    assign sel_out   = sel_out_r;
    assign sel_valid = sel_valid_r;
    assign collision = collision_r;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Testbench for bus_grant_encoder: six instances (N=24/2/33, both modes),
// a behavioural reference model feeding a timestamped scoreboard, and
// directed scenario tasks with their own literal checks.
module tb_bus_grant_encoder;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [23:0] req24 = 24'd0;
    logic [1:0]  req2  = 2'd0;
    logic [32:0] req33 = 33'd0;
    logic        hold = 1'b0;
    logic        err_clear = 1'b0;

    logic [4:0] sel0, sel1;
    logic [0:0] sel2, sel3;
    logic [5:0] sel4, sel5;
    logic       vld0, vld1, vld2, vld3, vld4, vld5;
    logic       col0, col1, col2, col3, col4, col5;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bus_grant_encoder #(.N(24), .MODE(MODE_FIXED)) u0 (.clk(clk), .clr(clr), .req(req24), .hold(hold),
        .err_clear(err_clear), .sel_out(sel0), .sel_valid(vld0), .collision(col0));
    bus_grant_encoder #(.N(24), .MODE(MODE_RR)) u1 (.clk(clk), .clr(clr), .req(req24), .hold(hold),
        .err_clear(err_clear), .sel_out(sel1), .sel_valid(vld1), .collision(col1));
    bus_grant_encoder #(.N(2), .MODE(MODE_FIXED)) u2 (.clk(clk), .clr(clr), .req(req2), .hold(hold),
        .err_clear(err_clear), .sel_out(sel2), .sel_valid(vld2), .collision(col2));
    bus_grant_encoder #(.N(2), .MODE(MODE_RR)) u3 (.clk(clk), .clr(clr), .req(req2), .hold(hold),
        .err_clear(err_clear), .sel_out(sel3), .sel_valid(vld3), .collision(col3));
    bus_grant_encoder #(.N(33), .MODE(MODE_FIXED)) u4 (.clk(clk), .clr(clr), .req(req33), .hold(hold),
        .err_clear(err_clear), .sel_out(sel4), .sel_valid(vld4), .collision(col4));
    bus_grant_encoder #(.N(33), .MODE(MODE_RR)) u5 (.clk(clk), .clr(clr), .req(req33), .hold(hold),
        .err_clear(err_clear), .sel_out(sel5), .sel_valid(vld5), .collision(col5));

    typedef struct { int sel; bit valid; bit coll; int last; } mstate_t;
    typedef struct { int due; int id; logic [31:0] sel; logic valid; logic coll; } exp_t;

    mstate_t ms [6];
    int      n_of    [6] = '{24, 24, 2, 2, 33, 33};
    int      mode_of [6] = '{0, 1, 0, 1, 0, 1};
    exp_t    q [$];

    // Reference behaviour written directly from the grant rules (linear scans, no reversal).
    function automatic mstate_t mstep(mstate_t s, logic [63:0] r, int n, int mode, bit h, bit e);
        mstate_t t;
        int cnt;
        int pick;
        int j;
        t = s;
        cnt = 0;
        pick = -1;
        for (int i = 0; i < n; i++) if (r[i]) cnt++;
        t.coll = (s.coll && !e) || (cnt > 1);
        if (h && s.valid) return t;
        if (cnt == 0) begin
            t.valid = 1'b0;
            return t;
        end
        if (mode == 0) begin
            for (int i = 0; i < n; i++) if (r[i]) pick = i;
        end else begin
            for (int k = 1; k <= n; k++) begin
                j = (s.last + k) % n;
                if (r[j] && pick < 0) pick = j;
            end
            t.last = pick;
        end
        t.sel = pick;
        t.valid = 1'b1;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            ms[i].sel = 0; ms[i].valid = 1'b0; ms[i].coll = 1'b0; ms[i].last = n_of[i] - 1;
        end
    endtask

    task automatic get_act(input int id, output logic [31:0] s, output logic v, output logic c);
        case (id)
            0: begin s = 32'(sel0); v = vld0; c = col0; end
            1: begin s = 32'(sel1); v = vld1; c = col1; end
            2: begin s = 32'(sel2); v = vld2; c = col2; end
            3: begin s = 32'(sel3); v = vld3; c = col3; end
            4: begin s = 32'(sel4); v = vld4; c = col4; end
            default: begin s = 32'(sel5); v = vld5; c = col5; end
        endcase
    endtask

    // Apply one cycle of inputs and queue the model's expectation for the next edge.
    task automatic drive_cycle(input logic [23:0] r24, input logic [1:0] r2, input logic [32:0] r33,
                               input logic h, input logic e);
        logic [63:0] r64;
        exp_t ex;
        req24 = r24; req2 = r2; req33 = r33; hold = h; err_clear = e;
        for (int i = 0; i < 6; i++) begin
            r64 = (i < 2) ? 64'(r24) : ((i < 4) ? 64'(r2) : 64'(r33));
            ms[i] = mstep(ms[i], r64, n_of[i], mode_of[i], h, e);
            ex.due = cyc + 1; ex.id = i; ex.sel = 32'(ms[i].sel);
            ex.valid = ms[i].valid; ex.coll = ms[i].coll;
            q.push_back(ex);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        clr = 1'b1; #1;
        clr = 1'b0;
        model_reset();
    endtask

    // Scoreboard: compare queued expectations once the edge they belong to has passed.
    initial begin
        exp_t ex;
        logic [31:0] a_sel;
        logic a_v, a_c;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                ex = q.pop_front();
                get_act(ex.id, a_sel, a_v, a_c);
                tests_run++;
                if (a_sel !== ex.sel || a_v !== ex.valid || a_c !== ex.coll) begin
                    tests_failed++;
                    $display("FAIL scoreboard dut%0d cyc%0d: got sel=%0d valid=%0b coll=%0b, expected sel=%0d valid=%0b coll=%0b",
                             ex.id, cyc, a_sel, a_v, a_c, ex.sel, ex.valid, ex.coll);
                end
            end
        end
    end

    task automatic test_reset();
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd0 || vld0 !== 1'b0 || col0 !== 1'b0 || vld1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got sel=%0d valid=%0b coll=%0b rrvalid=%0b, expected 0/0/0/0", sel0, vld0, col0, vld1);
        end
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        drive_cycle(24'h000080, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd7 || vld0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL grant7: got sel=%0d valid=%0b, expected 7/1", sel0, vld0);
        end
        @(negedge clk); #1;
        clr = 1'b1; #1;
        tests_run++;
        if (sel0 !== 5'd0 || vld0 !== 1'b0 || col0 !== 1'b0 || sel1 !== 5'd0 || vld1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got sel=%0d valid=%0b coll=%0b rrsel=%0d, expected 0/0/0/0", sel0, vld0, col0, sel1);
        end
        clr = 1'b0;
        model_reset();
        drive_cycle(24'h001000, 2'b00, 33'd0, 1'b0, 1'b0);
        tests_run++;
        if (vld0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_edge_valid: got valid=%0b, expected 0", vld0);
        end
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd12 || vld0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_grant_after_reset: got sel=%0d valid=%0b, expected 12/1", sel0, vld0);
        end
    endtask

    task automatic test_fixed();
        drive_cycle(24'h800008, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd23 || vld0 !== 1'b1 || col0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL fixed_highest: got sel=%0d valid=%0b coll=%0b, expected 23/1/1", sel0, vld0, col0);
        end
        drive_cycle(24'h000000, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd23 || vld0 !== 1'b0 || col0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL fixed_idle: got sel=%0d valid=%0b coll=%0b, expected 23/0/1", sel0, vld0, col0);
        end
    endtask

    task automatic test_rr();
        int exp_seq [4] = '{2, 5, 23, 2};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(24'h800024, 2'b00, 33'd0, 1'b0, 1'b0);
            @(posedge clk); #1;
            tests_run++;
            if (32'(sel1) !== exp_seq[i] || vld1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_seq[%0d]: got sel=%0d valid=%0b, expected %0d/1", i, sel1, vld1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive_cycle(24'h000020, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(24'h000200, 2'b00, 33'd0, 1'b1, 1'b0);
            @(posedge clk); #1;
            tests_run++;
            if (sel0 !== 5'd5 || sel1 !== 5'd5 || vld0 !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got sel=%0d rrsel=%0d valid=%0b, expected 5/5/1", i, sel0, sel1, vld0);
            end
        end
        drive_cycle(24'h000200, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd9 || sel1 !== 5'd9) begin
            tests_failed++;
            $display("FAIL hold_release: got sel=%0d rrsel=%0d, expected 9/9", sel0, sel1);
        end
        drive_cycle(24'h000000, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_cycle(24'h000040, 2'b00, 33'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        tests_run++;
        if (sel0 !== 5'd6 || vld0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_while_invalid: got sel=%0d valid=%0b, expected 6/1", sel0, vld0);
        end
    endtask

    task automatic test_collision();
        drive_cycle(24'h000012, 2'b00, 33'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_cycle(24'h000004, 2'b00, 33'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (col0 !== 1'b0 || col1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_clear: got coll=%0b/%0b, expected 0/0", col0, col1);
        end
        drive_cycle(24'h000012, 2'b00, 33'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        tests_run++;
        if (col0 !== 1'b1 || col1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_set_wins: got coll=%0b/%0b, expected 1/1", col0, col1);
        end
    endtask

    task automatic test_sweep();
        int exp5 [3] = '{0, 32, 0};
        int exp3 [3] = '{0, 1, 0};
        tests_run++;
        if (u2.W !== 1 || u4.W !== 6) begin
            tests_failed++;
            $display("FAIL width: got W2=%0d W33=%0d, expected 1/6", u2.W, u4.W);
        end
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(24'd0, 2'b11, 33'h100000001, 1'b0, 1'b0);
            @(posedge clk); #1;
            tests_run++;
            if (32'(sel5) !== exp5[i] || 32'(sel3) !== exp3[i] || sel4 !== 6'd32 || sel2 !== 1'b1) begin
                tests_failed++;
                $display("FAIL sweep_wrap[%0d]: got rr33=%0d rr2=%0d fx33=%0d fx2=%0d, expected %0d/%0d/32/1",
                         i, sel5, sel3, sel4, sel2, exp5[i], exp3[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] r24;
        logic [32:0] r33;
        for (int i = 0; i < 60; i++) begin
            r24 = 24'($urandom) & 24'($urandom) & 24'($urandom);
            r33 = {1'($urandom), 32'($urandom) & 32'($urandom) & 32'($urandom)};
            drive_cycle(r24, 2'($urandom), r33, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            @(posedge clk); #1;
            tests_run++;
            if (sel4 >= 6'd33 || sel5 >= 6'd33) begin
                tests_failed++;
                $display("FAIL range33[%0d]: got fx=%0d rr=%0d, expected both < 33", i, sel4, sel5);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_fixed();
        test_rr();
        test_hold();
        test_collision();
        test_sweep();
        test_back_to_back();
        drive_cycle(24'd0, 2'b00, 33'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_grant_encoder.md
# bus_grant_encoder

Registered, parametrised successor to the datapath's combinational source encoder. It converts N one-hot (or multi-hot) bus-drive requests into a binary source select for the shared bus multiplexer, with a valid flag, a hold input that freezes the grant across multi-cycle transfers, a sticky collision flag, and a selectable fixed-priority or round-robin arbitration mode. It sits between the control unit's `*out` strobes and the bus mux select input.

## Interface
- `N`, default 24: number of request inputs (2..64).
- `W`, default `$clog2(N)`: select width. Derived; never overridden.
- `MODE`, default 0: arbitration mode.
  - 0 = fixed priority, highest index wins.
  - 1 = round-robin.

- `clk` in 1: system clock, rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `req` in N: request vector; bit i requests bus source i.
- `hold` in 1: freeze the current grant while `sel_valid`=1.
- `err_clear` in 1: clears `collision`.
- `sel_out` out W: registered binary index of the granted source.
- `sel_valid` out 1: registered; 1 when `sel_out` is a live grant.
- `collision` out 1: sticky; set when more than one `req` bit was high in a sampled cycle.

## Operation
- Reset (`clr`=1, asynchronous):
  - `sel_out`=0, `sel_valid`=0, `collision`=0.
  - Round-robin pointer `last`=N-1, so the first RR search starts at index 0.
- Each rising edge with `clr`=0:
  - If `hold`=1 and `sel_valid`=1: `sel_out`, `sel_valid` and `last` are unchanged. `hold` takes priority over `req`, even when the granted bit has dropped.
  - Otherwise, if `req`=0: `sel_valid`←0, `sel_out` keeps its previous value, and `last` is unchanged.
  - Otherwise, in MODE 0: `sel_out`←highest set index of `req`, and `sel_valid`←1.
  - Otherwise, in MODE 1: scan upward from `last`+1, wrapping N-1→0, and take the first set bit. Then `sel_out`←that index, `last`←that index, and `sel_valid`←1.
- `hold`=1 while `sel_valid`=0 is ignored; a normal grant is made.
- `collision`:
  - Sampled every edge, including hold cycles.
  - Next value = (`collision` & ~`err_clear`) | (popcount(`req`)>1).
  - If a new collision and `err_clear` occur in the same cycle, the set wins.
- Indices ≥N are never produced. In RR mode, the wrap compares against N-1, not 2^W-1.

## Timing
- Latency is 1 cycle: `req` sampled at edge k appears on `sel_out`/`sel_valid` after edge k.
- All outputs come directly from flops; there is no combinational input-to-output path.
- `hold` and `err_clear` are sampled on the same edge as `req`.
- Reset asserted mid-grant forces all outputs to their reset values immediately, without waiting for a clock edge. After `clr` deasserts, the first grant appears after the first edge.
- Throughput: a new grant on every cycle in which `hold` is low.

## Structure
- Shared package `bus_pkg`: `MODE_FIXED`=0, `MODE_RR`=1, and `BUS_SRC_N`=24 (the default source count for the datapath).
- Sub-module `prio_pick`: purely combinational. Inputs are `req[N]` and a start index; outputs are `found` and `idx[W]`, giving the first set bit scanning upward from the start index with wrap.
  - MODE 0 implements highest-wins by feeding the bit-reversed `req` with start 0 and mapping the result back as N-1-idx. Mapping back keeps one picker for both modes.
- The top level holds only the flops (`sel_out`, `sel_valid`, `last`, `collision`), the popcount>1 detect, and the hold/next-state muxing.

## Test plan
- Reset: assert `clr` asynchronously mid-grant while `sel_out`=7. Required: `sel_out`=0, `sel_valid`=0, `collision`=0 before the next edge, and the first grant lands 1 cycle after deassert.
- MODE 0, N=24, `req`=bit 23 | bit 3. Required: `sel_out`=23 and `sel_valid`=1 one cycle later, with `collision`=1. Then `req`=0. Required: `sel_valid`=0 with `sel_out` held at 23.
- MODE 1, `req`=bits {2,5,23} held constant for 4 cycles. Required grant sequence: 2, 5, 23, 2 (wraps at 23→0, never emits 24..31).
- Hold: grant 5, then assert `hold` for 3 cycles while `req` changes to bit 9 only. Required: `sel_out` stays 5. After `hold` drops, `sel_out`=9 one cycle later.
- Collision clear: after `collision`=1, pulse `err_clear` with a one-hot `req`. Required: `collision`=0 next cycle. Repeat `err_clear` with `req`=bits {1,4}. Required: `collision` remains 1 (set wins).
- Parameter sweep at N=2 and N=33 in both modes. Required: `sel_out` always < N, and `W` resolves to 1 and 6 respectively.
